// File: rtl/sw_input_reg.sv
// Read-only switch input register: per-channel synchroniser, debounce filter and
// sticky change flags, read over a simple strobe interface with a maskable irq.
module sw_input_reg #(
    parameter int NCH          = 4,
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int ACTIVE_LOW   = 0,
    parameter int PAD_BIT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              sel,
    input  logic [NCH-1:0]    irq_mask,
    input  logic [NCH-1:0]    sw_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              irq
);

    localparam int             CW  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  TC  = CW'(DEBOUNCE_CYC - 1);
    localparam logic           PAD = (PAD_BIT != 0);
    localparam logic           INV = (ACTIVE_LOW != 0);

    logic [NCH-1:0]    s1, s2, lvl;
    logic [NCH-1:0]    stable, stable_next;
    logic [NCH-1:0]    chg, chg_next, chg_set;
    logic [CW-1:0]     cnt      [NCH];
    logic [CW-1:0]     cnt_next [NCH];
    logic [DATA_W-1:0] rd_data;
    logic              irq_next;

    assign lvl = INV ? ~s2 : s2;

    always_comb begin
        stable_next = stable;
        chg_set     = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_next[i] = '0;
            if (lvl[i] != stable[i]) begin
                if (cnt[i] == TC) begin
                    stable_next[i] = lvl[i];
                    chg_set[i]     = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // A flag set in the same cycle as a clearing read survives the clear.
    always_comb begin
        chg_next = ((rd_en && sel) ? '0 : chg) | chg_set;
        irq_next = |(chg_next & irq_mask);
        rd_data  = {DATA_W{PAD}};
        rd_data[NCH-1:0] = sel ? chg : stable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            chg      <= '0;
            data_out <= {DATA_W{PAD}};
            rd_valid <= 1'b0;
            irq      <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            s1       <= sw_in;
            s2       <= s1;
            stable   <= stable_next;
            chg      <= chg_next;
            irq      <= irq_next;
            rd_valid <= rd_en;
            if (rd_en) data_out <= rd_data;
            for (int i = 0; i < NCH; i++) cnt[i] <= cnt_next[i];
        end
    end

endmodule

// File: tb/tb_sw_input_reg.sv
// Scoreboard bench for sw_input_reg: directed scenarios then random traffic,
// checked against a history-based behavioural model.
module tb_sw_input_reg;

    localparam int NCH = 4;
    localparam int DATA_W = 8;
    localparam int DEB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rd_en = 1'b0;
    logic              sel = 1'b0;
    logic [NCH-1:0]    irq_mask = '0;
    logic [NCH-1:0]    sw_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              irq;

    sw_input_reg #(
        .NCH(NCH), .DATA_W(DATA_W), .DEBOUNCE_CYC(DEB), .ACTIVE_LOW(0), .PAD_BIT(1)
    ) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .sel(sel), .irq_mask(irq_mask),
        .sw_in(sw_in), .data_out(data_out), .rd_valid(rd_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              irq;
        logic              rv;
        logic [DATA_W-1:0] data;
    } cyc_t;

    cyc_t              cyc_q[$];
    logic [DATA_W-1:0] rd_q[$];
    int                checks = 0;
    int                failures = 0;

    // Behavioural model: lvl is the input seen two edges earlier; a channel
    // accepts a new level once its last DEB lvl samples all disagree with stable.
    logic [NCH-1:0]    m_s1, m_s2, m_stable, m_chg;
    logic [NCH-1:0]    lvl_hist[$];
    logic [DATA_W-1:0] m_data;
    logic              m_irq;

    task automatic model_edge();
        cyc_t c;
        logic [NCH-1:0] lvl, flip;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0;
            lvl_hist.delete();
            m_data = '1; m_irq = 1'b0;
            c.rv = 1'b0;
        end else begin
            lvl = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_in;
            lvl_hist.push_back(lvl);
            if (lvl_hist.size() > DEB) void'(lvl_hist.pop_front());
            flip = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (lvl_hist.size() == DEB) begin
                    flip[ch] = 1'b1;
                    foreach (lvl_hist[k])
                        if (lvl_hist[k][ch] == m_stable[ch]) flip[ch] = 1'b0;
                end
            end
            c.rv = rd_en;
            if (rd_en) begin
                m_data = {4'hF, (sel ? m_chg : m_stable)};
                rd_q.push_back(m_data);
                if (sel) m_chg = '0;
            end
            m_chg    = m_chg | flip;
            m_stable = m_stable ^ flip;
            m_irq    = |(m_chg & irq_mask);
        end
        c.irq  = m_irq;
        c.data = m_data;
        cyc_q.push_back(c);
    endtask

    // Apply inputs on the falling edge, then let the model predict the next rising edge.
    task automatic tick(input logic r, input logic re, input logic s,
                        input logic [NCH-1:0] m, input logic [NCH-1:0] sw);
        @(negedge clk);
        reset = r; rd_en = re; sel = s; irq_mask = m; sw_in = sw;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, sel, irq_mask, sw_in);
    endtask

    task automatic rd(input logic s);
        tick(1'b0, 1'b1, s, irq_mask, sw_in);
    endtask

    // Monitor: per-cycle irq/rd_valid/data_out, plus read-data scoreboard on rd_valid.
    always @(posedge clk) begin
        cyc_t e;
        logic [DATA_W-1:0] d;
        #1;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e.irq);
            end
            checks++;
            if (rd_valid !== e.rv) begin
                failures++;
                $display("FAIL rd_valid t=%0t got=%b exp=%b", $time, rd_valid, e.rv);
            end
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL data_out_hold t=%0t got=%h exp=%h", $time, data_out, e.data);
            end
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected t=%0t data=%h exp=none", $time, data_out);
            end else begin
                d = rd_q.pop_front();
                if (data_out !== d) begin
                    failures++;
                    $display("FAIL rd_data t=%0t got=%h exp=%h", $time, data_out, d);
                end
            end
        end
    end

    initial begin
        // reset with inputs high, then an immediate state read
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
        tick(1'b1, 1'b1, 1'b0, 4'h0, 4'hF);
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        idle(10);
        rd(1'b1);
        // clean edge on ch0
        tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h1);
        idle(7);
        rd(1'b0);
        idle(2);
        // bounce on ch1
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h3);
            tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h1);
        end
        idle(8);
        rd(1'b0);
        // unmask ch0, read-to-clear twice
        tick(1'b0, 1'b0, 1'b0, 4'h1, 4'h1);
        idle(2);
        rd(1'b1);
        rd(1'b1);
        idle(2);
        // collision: ch2 accepts on the same edge as a clearing read
        tick(1'b0, 1'b0, 1'b0, 4'h5, 4'h5);
        idle(4);
        rd(1'b1);
        idle(1);
        rd(1'b1);
        idle(2);
        // reset in the middle of a ch3 debounce
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'hD);
        idle(4);
        tick(1'b1, 1'b0, 1'b0, 4'hF, 4'hD);
        idle(5);
        rd(1'b0);
        idle(1);
        rd(1'b0);
        rd(1'b1);
        // random traffic with sticky, slowly changing inputs
        for (int i = 0; i < 600; i++) begin
            logic [NCH-1:0] sw;
            sw = sw_in;
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 9) == 0) sw[ch] = ~sw[ch];
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? NCH'($urandom) : irq_mask, sw);
        end
        idle(3);
        @(negedge clk);
        checks++;
        if (cyc_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", cyc_q.size(), rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
